// File: rtl/median_sort49.sv
// rtl/median_sort49.sv - running 49-entry sorted window with single-cycle delete/insert and median output
// One parallel compare/shift network: each slot picks S[i-1], S[i], S[i+1] or INS per update.
module median_sort49 #(
  parameter int N = 49
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       SE,
  input  logic [7:0] INS,
  input  logic [7:0] DEL,
  output logic [7:0] MED
);

  logic [7:0]   s_q [N];
  logic [7:0]   s_d [N];
  logic [N-1:0] eq;
  logic [N-1:0] nohit;
  logic [7:0]   r [N-1];
  logic [N-2:0] rlt;

  // nohit[j] means slot j sits below the removal index; an absent DEL evicts the top slot.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eq[i] = (s_q[i] == DEL);
    end
    nohit[0] = ~eq[0];
    for (int i = 1; i < N; i++) begin
      nohit[i] = nohit[i-1] & ~eq[i];
    end
    for (int j = 0; j < N - 1; j++) begin
      r[j]   = nohit[j] ? s_q[j] : s_q[j+1];
      rlt[j] = (r[j] < INS);
    end
  end

  // The remainder is sorted, so rlt is a run of ones then zeros; INS lands at the boundary.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_d[i] = INS;
    end
    s_d[0] = rlt[0] ? r[0] : INS;
    for (int i = 1; i < N - 1; i++) begin
      if (rlt[i]) begin
        s_d[i] = r[i];
      end else if (!rlt[i-1]) begin
        s_d[i] = r[i-1];
      end else begin
        s_d[i] = INS;
      end
    end
    s_d[N-1] = rlt[N-2] ? INS : r[N-2];
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        s_q[i] <= 8'hff;
      end
    end else if (!SE) begin
      for (int i = 0; i < N; i++) begin
        s_q[i] <= s_d[i];
      end
    end
  end

  assign MED = s_q[(N-1)/2];

endmodule
